// File: rtl/occupancy_grid_updater_pkg.sv
// Shared types and default log-odds constants for the occupancy grid updater.
package occupancy_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    DRAIN,
    CLEAR
  } updater_state_t;

  localparam int unsigned DEF_X_W = 8;
  localparam int unsigned DEF_Y_W = 8;

  // Request record for the default map geometry; map address is {y, x}.
  typedef struct packed {
    logic               free;
    logic [DEF_Y_W-1:0] y;
    logic [DEF_X_W-1:0] x;
  } occ_req_t;

  localparam int L_OCC_DEFAULT  = 7;
  localparam int L_FREE_DEFAULT = -3;
  localparam int L_MAX_DEFAULT  = 127;
  localparam int L_MIN_DEFAULT  = -127;

endpackage

// File: rtl/occupancy_grid_updater_if.sv
// Tracer-side request, status and map RAM signals of the updater.
// master is the updater's view, slave is the tracer/RAM environment's view.
interface occupancy_grid_updater_if #(
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 8,
  parameter int unsigned CELL_W = 8
);
  logic                 req_valid;
  logic                 req_free;
  logic [X_W-1:0]       req_x;
  logic [Y_W-1:0]       req_y;
  logic                 clear_req;
  logic                 busy;
  logic                 overflow;
  logic                 mem_rd_en;
  logic [X_W+Y_W-1:0]   mem_rd_addr;
  logic [CELL_W-1:0]    mem_rd_data;
  logic                 mem_wr_en;
  logic [X_W+Y_W-1:0]   mem_wr_addr;
  logic [CELL_W-1:0]    mem_wr_data;

  modport master (
    input  req_valid, req_free, req_x, req_y, clear_req, mem_rd_data,
    output busy, overflow, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output req_valid, req_free, req_x, req_y, clear_req, mem_rd_data,
    input  busy, overflow, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/occupancy_grid_updater_req_fifo.sv
// Show-ahead request FIFO with a flush that still accepts a same-cycle push.
module occupancy_req_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic             do_push, do_pop;

  // After a flush the queue is empty, so a same-cycle push lands in slot 0.
  assign do_push = push & (flush | ~full);
  assign do_pop  = pop & ~empty & ~flush;
  assign wr_idx  = flush ? '0 : wr_ptr[AW-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/occupancy_grid_updater.sv
// Saturating log-odds read-modify-write of the map RAM, fed by the ray tracer,
// with a whole-map clear sweep.
module occupancy_grid_updater
  import occupancy_pkg::*;
#(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned CELL_W     = 8,
  parameter int          L_OCC      = L_OCC_DEFAULT,
  parameter int          L_FREE     = L_FREE_DEFAULT,
  parameter int          L_MAX      = L_MAX_DEFAULT,
  parameter int          L_MIN      = L_MIN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  occupancy_grid_updater_if.master bus
);
  localparam int unsigned A_W   = X_W + Y_W;
  localparam int unsigned REQ_W = 1 + A_W;
  localparam logic [A_W-1:0]         LAST_ADDR = '1;
  localparam logic signed [CELL_W:0] INC_OCC   = (CELL_W+1)'(L_OCC);
  localparam logic signed [CELL_W:0] INC_FREE  = (CELL_W+1)'(L_FREE);
  localparam logic signed [CELL_W:0] SAT_MAX   = (CELL_W+1)'(L_MAX);
  localparam logic signed [CELL_W:0] SAT_MIN   = (CELL_W+1)'(L_MIN);

  updater_state_t state, state_next;

  logic              clear_start, drop;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]  head;
  logic              s1_valid, s1_free;
  logic [A_W-1:0]    s1_addr;
  logic              fwd_valid;
  logic [A_W-1:0]    fwd_addr;
  logic [CELL_W-1:0] fwd_data;
  logic [A_W-1:0]    clr_addr;
  logic              overflow_q;
  logic [CELL_W-1:0] old_val, new_val;
  logic signed [CELL_W:0] sum;

  assign clear_start = bus.clear_req && (state == NORMAL);
  assign drop        = bus.req_valid && fifo_full && !clear_start;
  assign fifo_pop    = (state == NORMAL) && !clear_start && !fifo_empty;

  occupancy_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.req_valid),
    .pop   (fifo_pop),
    .flush (clear_start),
    .din   ({bus.req_free, bus.req_y, bus.req_x}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The RAM returns pre-write data when stage 2 rewrites the cell being read.
  always_comb begin
    old_val = bus.mem_rd_data;
    if (fwd_valid && (fwd_addr == s1_addr)) old_val = fwd_data;
    sum = $signed({old_val[CELL_W-1], old_val}) + (s1_free ? INC_FREE : INC_OCC);
    if (sum > SAT_MAX)      new_val = SAT_MAX[CELL_W-1:0];
    else if (sum < SAT_MIN) new_val = SAT_MIN[CELL_W-1:0];
    else                    new_val = sum[CELL_W-1:0];
  end

  always_comb begin
    state_next      = state;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    unique case (state)
      NORMAL: if (bus.clear_req) state_next = DRAIN;
      DRAIN:  if (!s1_valid) state_next = CLEAR;
      CLEAR:  if (clr_addr == LAST_ADDR) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
    if (fifo_pop) begin
      bus.mem_rd_en   = 1'b1;
      bus.mem_rd_addr = head[A_W-1:0];
    end
    if (state == CLEAR) begin
      bus.mem_wr_en   = 1'b1;
      bus.mem_wr_addr = clr_addr;
    end else if (s1_valid) begin
      bus.mem_wr_en   = 1'b1;
      bus.mem_wr_addr = s1_addr;
      bus.mem_wr_data = new_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      s1_valid   <= 1'b0;
      s1_free    <= 1'b0;
      s1_addr    <= '0;
      fwd_valid  <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      clr_addr   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state    <= state_next;
      s1_valid <= fifo_pop;
      if (fifo_pop) begin
        s1_addr <= head[A_W-1:0];
        s1_free <= head[REQ_W-1];
      end
      fwd_valid <= s1_valid;
      if (s1_valid) begin
        fwd_addr <= s1_addr;
        fwd_data <= new_val;
      end
      if (state == CLEAR) clr_addr <= clr_addr + A_W'(1);
      if (clear_start)  overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
    end
  end

  assign bus.busy     = !fifo_empty || s1_valid || (state != NORMAL);
  assign bus.overflow = overflow_q;
endmodule

// File: doc/occupancy_grid_updater.md
# occupancy_grid_updater

Applies log-odds occupancy updates to the grid map memory. Sits directly downstream of the Bresenham ray tracer: it consumes each per-cell update pulse (cell coordinates plus free/occupied flag) and performs a saturating read-modify-write on an external dual-port map RAM. It reports `busy` back to the tracer, which holds off new rays while busy is high. It also provides a whole-map clear sweep.

## Interface
- `X_W`, default 8: cell x coordinate width.
- `Y_W`, default 8: cell y coordinate width; map address is {y, x}, `X_W+Y_W` bits.
- `CELL_W`, default 8: signed log-odds cell width.
- `L_OCC`, default +7: increment for an occupied hit.
- `L_FREE`, default -3: increment for a free pass.
- `L_MAX`, default +127: upper saturation bound.
- `L_MIN`, default -127: lower saturation bound.
- `FIFO_DEPTH`, default 4: request FIFO depth; must be a power of two.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  update request strobe; driven by the tracer's write enable.
- `req_free`  in  1  1 = free-cell update, 0 = occupied; driven by the tracer's cell-is-free output.
- `req_x`  in  X_W  cell x.
- `req_y`  in  Y_W  cell y.
- `clear_req`  in  1  one-cycle pulse that starts a map clear.
- `busy`  out  1  high while any work is pending.
- `overflow`  out  1  sticky flag: a request was dropped.
- `mem_rd_en`  out  1  RAM read enable.
- `mem_rd_addr`  out  X_W+Y_W  RAM read address.
- `mem_rd_data`  in  CELL_W  RAM read data, valid 1 cycle after `mem_rd_en`. Read-during-write returns old data.
- `mem_wr_en`  out  1  RAM write enable.
- `mem_wr_addr`  out  X_W+Y_W  RAM write address.
- `mem_wr_data`  out  CELL_W  RAM write data.

## Operation
- **Request FIFO**
  - Accepts a request when `req_valid` is high and the FIFO is not full.
  - Stores {free, y, x}.
  - If `req_valid` is high while the FIFO is full, the request is dropped and `overflow` is set.
- **Stage 1 (read)**
  - In NORMAL, pops the FIFO head when it is non-empty.
  - Drives `mem_rd_en`=1 and `mem_rd_addr`={y, x}.
  - Registers the address, free flag and a valid bit.
- **Stage 2 (update)**
  - old = `mem_rd_data`, except for a one-back hazard: if stage 2 wrote the same address in the previous cycle, old is that written value instead.
  - new = clamp(old + (free ? L_FREE : L_OCC), L_MIN, L_MAX).
  - Sum computed at CELL_W+1 bits, signed.
  - Drives `mem_wr_en`=1, `mem_wr_addr`, `mem_wr_data`=new.
  - Records the last written address, data and valid for forwarding.
- **FSM states:** NORMAL, DRAIN, CLEAR.
  - **NORMAL → DRAIN** on `clear_req`.
    - The FIFO is flushed in that cycle; those updates would be erased anyway.
    - A `req_valid` in the same cycle is enqueued after the flush and kept.
    - `overflow` is cleared.
  - **DRAIN:** no pops. Goes to CLEAR once stages 1 and 2 are empty.
  - **CLEAR:** a counter writes 0 to addresses 0 through 2^(X_W+Y_W)-1, one per cycle. No reads. Goes to NORMAL after the last address.
  - `clear_req` is ignored in DRAIN and CLEAR.
  - New requests keep enqueueing during DRAIN and CLEAR, and overflow when the FIFO is full.
- `busy` = FIFO non-empty | stage 1 valid | stage 2 valid | state ≠ NORMAL. It is decoded from registers only, with no combinational input path.

## Timing
- **Reset:** all outputs are 0, the FIFO is empty, stage valids are cleared, and the FSM is in NORMAL. Map RAM contents are not reset.
- **Latency, empty pipeline:** request at cycle t → `mem_rd_en` at t+1 → `mem_wr_en` at t+2.
- **Throughput:** 1 update per cycle. The tracer issues at most 1 per 2 cycles, so the FIFO does not fill in NORMAL.
- `busy` rises the cycle after the first accepted request. It falls the cycle after the final write or the final clear write.
- **Clear duration:** `clear_req` at t; DRAIN lasts ≤2 cycles; then 2^(X_W+Y_W) write cycles.
- **Reset asserted mid-operation:** in-flight and queued updates are lost and the clear is abandoned. Behaviour returns to the reset state immediately.

## Structure
- **Package `occupancy_pkg`**
  - `updater_state_t` enum {NORMAL, DRAIN, CLEAR}.
  - Packed `occ_req_t` {free, y, x}.
  - Default log-odds constants L_OCC, L_FREE, L_MAX, L_MIN.
- **Sub-module `occupancy_req_fifo`**
  - Synchronous show-ahead FIFO.
  - Parameterised width and depth.
  - Ports: push, pop, flush, full, empty.
- The top level contains the FSM, the two pipeline stages, the forwarding register and the clear counter.

## Test plan
- **Single update:** RAM[0x0305]=10; single req_valid with x=5, y=3, free=0 at t → `mem_rd_en` at t+1 with addr 0x0305; `mem_wr_en` at t+2 with data 17. `busy` high at t+1 and t+2, low at t+3.
- **Forwarding:** RAM[0x0102]=0; two back-to-back free requests to x=2, y=1 (FIFO preloaded) → writes -3 then -6, not -3 twice.
- **Saturation:** cell holding 125 gets an occupied update → 127. Cell holding -126 gets a free update → -127. Cell holding 127 gets an occupied update → 127.
- **Overflow:** 5 requests during CLEAR → `overflow`=1 and the 5th is dropped. After the clear, exactly 4 writes to the first 4 addresses, with values L_OCC or L_FREE applied to 0.
- **Clear:** `clear_req` pulse with an idle pipeline → 65536 writes of 0 covering addresses 0x0000 to 0xFFFF in order. No `mem_rd_en` during the sweep. `busy` drops afterwards.
- **Reset mid-clear:** `reset` low at address 0x1234 → all outputs 0 and `busy` 0 in the same cycle. After release, a request is processed normally with 2-cycle latency.
